// File: rtl/xnor_conv_pe_array_pkg.sv
// Shared constants, activation-select encoding and popcount helper for the
// binary 3x3 convolution PE array.
package xnor_conv_pe_array_pkg;

   localparam int unsigned NUM_PE = 9;
   localparam int unsigned ROWS   = 3;
   localparam int unsigned COLS   = 3;
   localparam int unsigned SUM_W  = 5;
   localparam logic [1:0]  CNT_INIT = 2'd3;

   typedef enum logic [1:0] {
      SelHold,
      SelIntop,
      SelRight,
      SelBelow
   } act_sel_e;

   // Pairwise adder tree over the nine XNOR bits.
   function automatic logic [3:0] popcount9(input logic [NUM_PE-1:0] v);
      logic [1:0] p0, p1, p2, p3;
      logic [2:0] q0, q1;
      p0 = {1'b0, v[0]} + {1'b0, v[1]};
      p1 = {1'b0, v[2]} + {1'b0, v[3]};
      p2 = {1'b0, v[4]} + {1'b0, v[5]};
      p3 = {1'b0, v[6]} + {1'b0, v[7]};
      q0 = {1'b0, p0} + {1'b0, p1};
      q1 = {1'b0, p2} + {1'b0, p3};
      return {1'b0, q0} + {1'b0, q1} + {3'b000, v[8]};
   endfunction

endpackage

// File: rtl/xnor_pe.sv
// One binary PE: weight bit, activation bit with a 4-way next-state mux,
// and the XNOR of the two.
module xnor_pe
   import xnor_conv_pe_array_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     w_load_i,
   input  logic     w_i,
   input  act_sel_e sel_i,
   input  logic     intop_i,
   input  logic     right_i,
   input  logic     below_i,
   output logic     a_o,
   output logic     xnor_o
);

   logic w_q, w_d;
   logic a_q, a_d;

   always_comb begin
      w_d = w_load_i ? w_i : w_q;
      a_d = a_q;
      unique case (sel_i)
         SelIntop: a_d = intop_i;
         SelRight: a_d = right_i;
         SelBelow: a_d = below_i;
         default:  a_d = a_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w_q <= 1'b0;
         a_q <= 1'b0;
      end else begin
         w_q <= w_d;
         a_q <= a_d;
      end
   end

   assign a_o    = a_q;
   assign xnor_o = ~(a_q ^ w_q);

endmodule

// File: rtl/xnor_conv_pe_array.sv
// 3x3 XNOR-popcount convolution array: nine PEs, popcount to a signed +/-1
// dot product, and a countdown that emits one valid result per window.
module xnor_conv_pe_array
   import xnor_conv_pe_array_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              weight_control,
   input  logic [NUM_PE-1:0] weight_in,
   input  logic [NUM_PE-1:0] top_start,
   input  logic [NUM_PE-1:0] top_control,
   input  logic [NUM_PE-1:0] side_control,
   input  logic              intop,
   output logic [SUM_W-1:0]  partial_sum_out,
   output logic              valid
);

   logic [NUM_PE-1:0] act;
   logic [NUM_PE-1:0] xnor_bits;
   logic [NUM_PE-1:0] right_n;
   logic [NUM_PE-1:0] below_n;
   act_sel_e          sel [NUM_PE];

   for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
      // Edge PEs see themselves as neighbour, so a shift there is a hold.
      if ((k % COLS) == COLS - 1) begin : g_right_edge
         assign right_n[k] = act[k];
      end else begin : g_right
         assign right_n[k] = act[k+1];
      end
      if ((k / COLS) == ROWS - 1) begin : g_bottom_edge
         assign below_n[k] = act[k];
      end else begin : g_below
         assign below_n[k] = act[k+COLS];
      end

      always_comb begin
         sel[k] = SelHold;
         if (top_start[k]) begin
            sel[k] = SelIntop;
         end else if (start && !top_control[k]) begin
            sel[k] = side_control[k] ? SelRight : SelBelow;
         end
      end

      xnor_pe u_pe (
         .clk_i    (clk),
         .rst_i    (rst),
         .w_load_i (weight_control),
         .w_i      (weight_in[k]),
         .sel_i    (sel[k]),
         .intop_i  (intop),
         .right_i  (right_n[k]),
         .below_i  (below_n[k]),
         .a_o      (act[k]),
         .xnor_o   (xnor_bits[k])
      );
   end

   logic [3:0]       pop;
   logic [SUM_W-1:0] sum;
   logic [1:0]       cnt_q, cnt_d;
   logic [SUM_W-1:0] psum_q, psum_d;
   logic             valid_q, valid_d;
   logic             capture;

   assign pop = popcount9(xnor_bits);
   // 2*pop - 9 wraps correctly into 5-bit two's complement.
   assign sum = {pop, 1'b0} - SUM_W'(NUM_PE);

   always_comb begin
      cnt_d   = cnt_q;
      capture = 1'b0;
      if (start) begin
         cnt_d = CNT_INIT;
      end else if (cnt_q != 2'd0) begin
         cnt_d   = cnt_q - 2'd1;
         capture = (cnt_q == 2'd1);
      end
      valid_d = capture;
      psum_d  = capture ? sum : psum_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= 2'd0;
         psum_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         psum_q  <= psum_d;
         valid_q <= valid_d;
      end
   end

   assign partial_sum_out = psum_q;
   assign valid           = valid_q;

endmodule

// File: tb/tb_xnor_conv_pe_array.sv
// Self-checking bench for xnor_conv_pe_array: directed windows plus random
// traffic against an array-level behavioural model.
module tb_xnor_conv_pe_array;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       weight_control;
   logic [8:0] weight_in;
   logic [8:0] top_start;
   logic [8:0] top_control;
   logic [8:0] side_control;
   logic       intop;
   logic [4:0] partial_sum_out;
   logic       valid;

   xnor_conv_pe_array dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .weight_control  (weight_control),
      .weight_in       (weight_in),
      .top_start       (top_start),
      .top_control     (top_control),
      .side_control    (side_control),
      .intop           (intop),
      .partial_sum_out (partial_sum_out),
      .valid           (valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int valid_seen = 0;

   // Reference model state
   bit       mw [9];
   bit       ma [9];
   int       since;      // edges since last start, -1 when no window pending
   bit       exp_valid;
   bit [4:0] exp_psum;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 9; k++) begin
         mw[k] = 1'b0;
         ma[k] = 1'b0;
      end
      since     = -1;
      exp_valid = 1'b0;
      exp_psum  = 5'd0;
   endtask

   function automatic int score();
      int s = 0;
      for (int k = 0; k < 9; k++) s += (ma[k] == mw[k]) ? 1 : -1;
      return s;
   endfunction

   task automatic model_edge(input bit st, input bit wc, input bit [8:0] wi, input bit [8:0] ts,
                             input bit [8:0] tc, input bit [8:0] sc, input bit it);
      bit na [9];
      exp_valid = 1'b0;
      if (st) begin
         since = 0;
      end else if (since >= 0) begin
         since++;
         if (since == 3) begin
            exp_valid = 1'b1;
            exp_psum  = 5'(score());
            since     = -1;
         end
      end
      for (int k = 0; k < 9; k++) begin
         na[k] = ma[k];
         if (ts[k]) na[k] = it;
         else if (st && !tc[k] && sc[k]) na[k] = (k % 3 == 2) ? ma[k] : ma[k+1];
         else if (st && !tc[k]) na[k] = (k / 3 == 2) ? ma[k] : ma[k+3];
      end
      for (int k = 0; k < 9; k++) begin
         ma[k] = na[k];
         if (wc) mw[k] = wi[k];
      end
   endtask

   task automatic tick(input bit st, input bit wc, input bit [8:0] wi, input bit [8:0] ts,
                       input bit [8:0] tc, input bit [8:0] sc, input bit it);
      start = st; weight_control = wc; weight_in = wi;
      top_start = ts; top_control = tc; side_control = sc; intop = it;
      @(posedge clk);
      model_edge(st, wc, wi, ts, tc, sc, it);
      #1;
      chk("valid", 32'(valid), 32'(exp_valid));
      chk("psum", 32'(partial_sum_out), 32'(exp_psum));
      if (valid === 1'b1) valid_seen++;
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, 9'h0, 9'h0, 9'h0, 9'h0, 1'b0);
   endtask

   task automatic serial_load(input bit [8:0] bits);
      for (int k = 0; k < 9; k++) tick(1'b0, 1'b0, 9'h0, 9'(1 << k), 9'h0, 9'h0, bits[k]);
   endtask

   // Start a window, then the capture lands on the third following edge.
   task automatic window(input bit [8:0] tc, input bit [8:0] sc, input string tag,
                         input bit use_lit, input bit [4:0] lit);
      tick(1'b1, 1'b0, 9'h0, 9'h0, tc, sc, 1'b0);
      idle();
      idle();
      chk({tag, "_early"}, 32'(valid), 32'd0);
      idle();
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      if (use_lit) chk({tag, "_value"}, 32'(partial_sum_out), 32'(lit));
      idle();
      chk({tag, "_pulse_end"}, 32'(valid), 32'd0);
   endtask

   localparam bit [8:0] Wt = 9'b101110000;

   initial begin
      // Reset with arbitrary inputs applied
      rst = 1'b1; start = 1'b1; weight_control = 1'b1; weight_in = 9'h1A5;
      top_start = 9'h0F3; top_control = 9'h055; side_control = 9'h0AA; intop = 1'b1;
      model_reset();
      #12;
      chk("reset_psum", 32'(partial_sum_out), 32'd0);
      chk("reset_valid", 32'(valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) idle();

      // Full match, one mismatching bit, full mismatch
      tick(1'b0, 1'b1, Wt, 9'h0, 9'h0, 9'h0, 1'b0);
      serial_load(Wt);
      window(9'h1FF, 9'h0, "full_match", 1'b1, 5'd9);
      tick(1'b0, 1'b0, 9'h0, 9'h001, 9'h0, 9'h0, ~Wt[0]);
      window(9'h1FF, 9'h0, "one_mismatch", 1'b1, 5'd7);
      serial_load(~Wt);
      window(9'h1FF, 9'h0, "full_mismatch", 1'b1, 5'b10111);

      // Side shift along row 0
      tick(1'b0, 1'b1, 9'h1FF, 9'h0, 9'h0, 9'h0, 1'b0);
      serial_load(9'b000000111);
      window(9'b111111100, 9'b000000011, "side_shift", 1'b0, 5'd0);

      // Vertical shift of the whole array
      serial_load(9'b111000000);
      window(9'h0, 9'h0, "vert_shift", 1'b1, 5'd3);

      // Restart one cycle after a start: only the second window reports
      valid_seen = 0;
      tick(1'b1, 1'b0, 9'h0, 9'h0, 9'h1FF, 9'h0, 1'b0);
      tick(1'b1, 1'b0, 9'h0, 9'h0, 9'h1FF, 9'h0, 1'b0);
      idle();
      idle();
      chk("restart_early", 32'(valid), 32'd0);
      idle();
      chk("restart_valid", 32'(valid), 32'd1);
      for (int i = 0; i < 4; i++) idle();
      chk("restart_count", 32'(valid_seen), 32'd1);

      // Reset mid-countdown aborts the window
      valid_seen = 0;
      tick(1'b1, 1'b0, 9'h0, 9'h0, 9'h1FF, 9'h0, 1'b0);
      idle();
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("midreset_psum", 32'(partial_sum_out), 32'd0);
      chk("midreset_valid", 32'(valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) idle();
      chk("midreset_no_valid", 32'(valid_seen), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         bit [8:0] ts;
         ts = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'(1 << $urandom_range(0, 8));
         tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 9'($urandom), ts,
              9'($urandom), 9'($urandom), 1'($urandom));
      end
      for (int i = 0; i < 4; i++) idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
